// File: rtl/operand_stack_pkg.sv
// Shared CPU definitions: operand-stack op codes, trap codes and stack FSM states.
package operand_stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_PUSH   = 3'd1,
    OP_POP    = 3'd2,
    OP_UNARY  = 3'd3,
    OP_BINARY = 3'd4
  } op_e;

  // Codes 1..3 belong to the existing CPU traps; stack traps start at 4.
  typedef enum logic [2:0] {
    TRAP_NONE            = 3'd0,
    TRAP_ILLEGAL_INSN    = 3'd1,
    TRAP_MISALIGNED      = 3'd2,
    TRAP_BREAKPOINT      = 3'd3,
    TRAP_STACK_OVERFLOW  = 3'd4,
    TRAP_STACK_UNDERFLOW = 3'd5
  } trap_e;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_TRAPPED = 2'd2
  } stack_state_e;

endpackage

// File: rtl/stack_ram.sv
// Single-port spill RAM: synchronous write, asynchronous read, no reset on contents.
module stack_ram #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned WORDS = 14,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/operand_stack.sv
// Operand stack: TOS/NOS in registers, deeper entries spilled to stack_ram, sticky traps.
module operand_stack
  import operand_stack_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               op,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         result,
  output logic [WIDTH-1:0]         second,
  output logic                     result_empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   depth,
  output logic [2:0]               trap
);

  localparam int unsigned DW        = $clog2(DEPTH) + 1;
  localparam int unsigned PW        = $clog2(DEPTH);
  localparam int unsigned RAM_WORDS = DEPTH - 2;
  localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);

  stack_state_e     state_q, state_d;
  trap_e            trap_q, trap_d;
  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] nos_q, nos_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             empty_q;

  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_rdata;

  logic accept, has1, has2, has3, at_full;

  stack_ram #(
    .WIDTH (WIDTH),
    .WORDS (RAM_WORDS),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (nos_q),
    .rdata (ram_rdata)
  );

  assign accept  = op_valid && (trap_q == TRAP_NONE);
  assign has1    = (depth_q != '0);
  assign has2    = (depth_q >= DW'(2));
  assign has3    = (depth_q >= DW'(3));
  assign at_full = (depth_q == DW'(DEPTH));

  // Next-state, datapath and spill-RAM control.
  always_comb begin
    state_d  = state_q;
    trap_d   = trap_q;
    tos_d    = tos_q;
    nos_d    = nos_q;
    depth_d  = depth_q;
    ptr_d    = ptr_q;
    ram_we   = 1'b0;
    // Read port sits on the newest spilled word; clamped so it never leaves range.
    ram_addr = (ptr_q == '0) ? '0 : RAM_AW'(ptr_q - PW'(1));

    if (accept) begin
      case (op)
        OP_PUSH: begin
          if (at_full) begin
            trap_d = TRAP_STACK_OVERFLOW;
          end else begin
            if (has2) begin
              ram_we   = 1'b1;
              ram_addr = RAM_AW'(ptr_q);
              ptr_d    = PW'(ptr_q + PW'(1));
            end
            nos_d   = tos_q;
            tos_d   = din;
            depth_d = DW'(depth_q + DW'(1));
          end
        end
        OP_POP: begin
          if (!has1) begin
            trap_d = TRAP_STACK_UNDERFLOW;
          end else begin
            tos_d   = nos_q;
            nos_d   = has3 ? ram_rdata : '0;
            if (has3) ptr_d = PW'(ptr_q - PW'(1));
            depth_d = DW'(depth_q - DW'(1));
          end
        end
        OP_UNARY: begin
          if (!has1) trap_d = TRAP_STACK_UNDERFLOW;
          else       tos_d  = din;
        end
        OP_BINARY: begin
          if (!has2) begin
            trap_d = TRAP_STACK_UNDERFLOW;
          end else begin
            tos_d   = din;
            nos_d   = has3 ? ram_rdata : '0;
            if (has3) ptr_d = PW'(ptr_q - PW'(1));
            depth_d = DW'(depth_q - DW'(1));
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_EMPTY: begin
        if (trap_d != TRAP_NONE)  state_d = ST_TRAPPED;
        else if (depth_d != '0)   state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (trap_d != TRAP_NONE)  state_d = ST_TRAPPED;
        else if (depth_d == '0)   state_d = ST_EMPTY;
      end
      ST_TRAPPED: state_d = ST_TRAPPED;
      default:    state_d = ST_TRAPPED;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      trap_q  <= TRAP_NONE;
      tos_q   <= '0;
      nos_q   <= '0;
      depth_q <= '0;
      ptr_q   <= '0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      depth_q <= depth_d;
      ptr_q   <= ptr_d;
      empty_q <= (depth_d == '0);
    end
  end

  assign result       = tos_q;
  assign second       = nos_q;
  assign depth        = depth_q;
  assign result_empty = empty_q;
  assign full         = at_full;
  assign trap         = trap_q;
  assign op_ready     = (trap_q == TRAP_NONE);

endmodule
